// File: rtl/regbank_access_arbiter.sv
// Arbitrates the single register-bank command port between a two-operand read requester and a write requester.
// Registered bank command one cycle after accept, read data two cycles after accept; the bank is cleared once after reset.
module regbank_access_arbiter #(
    parameter int MAX_WR_BURST = 4,
    parameter bit ZERO_REG     = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rd_valid,
    output logic        rd_ready,
    input  logic [4:0]  rd_sel0,
    input  logic [4:0]  rd_sel1,
    output logic        rd_rsp_valid,
    output logic [31:0] rd_data0,
    output logic [31:0] rd_data1,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [4:0]  wr_sel,
    input  logic [31:0] wr_data,
    output logic        bank_csbar,
    output logic        bank_rdwrbar,
    output logic [4:0]  bank_sel_src0,
    output logic [4:0]  bank_sel_src1,
    output logic [4:0]  bank_sel_dst,
    output logic [31:0] bank_wdata,
    output logic        bank_rst_n,
    input  logic [31:0] bank_src0,
    input  logic [31:0] bank_src1
);
    localparam int SW = $clog2(MAX_WR_BURST + 1);

    typedef enum logic [1:0] {INIT, CLR, RUN} state_t;

    state_t        state, state_next;
    logic [SW-1:0] wr_streak;
    logic          streak_full;
    logic          wr_grant, rd_grant, wr_drop;
    logic          cmd_rd, cmd_mask0, cmd_mask1;
    logic          rsp_mask0, rsp_mask1;

    assign streak_full = (wr_streak == SW'(MAX_WR_BURST));
    assign wr_drop     = ZERO_REG && (wr_sel == 5'd0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= INIT;
        else       state <= state_next;
    end

    // Writes win unless a read has already watched MAX_WR_BURST writes go past it.
    always_comb begin
        state_next = state;
        wr_grant   = 1'b0;
        rd_grant   = 1'b0;
        case (state)
            INIT: state_next = CLR;
            CLR:  state_next = RUN;
            RUN: begin
                wr_grant = wr_valid && !(rd_valid && streak_full);
                rd_grant = rd_valid && !wr_grant;
            end
            default: state_next = INIT;
        endcase
    end

    assign wr_ready   = wr_grant;
    assign rd_ready   = rd_grant;
    assign bank_rst_n = (state == RUN);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_streak <= '0;
        end else if (wr_grant && rd_valid) begin
            if (!streak_full) wr_streak <= wr_streak + SW'(1);
        end else if (rd_grant || !rd_valid) begin
            wr_streak <= '0;
        end
    end

    // Sel/wdata hold their last value while idle; bank_csbar=1 makes them don't-care.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bank_csbar    <= 1'b1;
            bank_rdwrbar  <= 1'b1;
            bank_sel_src0 <= '0;
            bank_sel_src1 <= '0;
            bank_sel_dst  <= '0;
            bank_wdata    <= '0;
            cmd_rd        <= 1'b0;
            cmd_mask0     <= 1'b0;
            cmd_mask1     <= 1'b0;
        end else begin
            bank_csbar <= !(rd_grant || (wr_grant && !wr_drop));
            cmd_rd     <= rd_grant;
            if (wr_grant && !wr_drop) begin
                bank_rdwrbar <= 1'b0;
                bank_sel_dst <= wr_sel;
                bank_wdata   <= wr_data;
            end else if (rd_grant) begin
                bank_rdwrbar  <= 1'b1;
                bank_sel_src0 <= rd_sel0;
                bank_sel_src1 <= rd_sel1;
                cmd_mask0     <= ZERO_REG && (rd_sel0 == 5'd0);
                cmd_mask1     <= ZERO_REG && (rd_sel1 == 5'd0);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_rsp_valid <= 1'b0;
            rsp_mask0    <= 1'b0;
            rsp_mask1    <= 1'b0;
        end else begin
            rd_rsp_valid <= cmd_rd;
            rsp_mask0    <= cmd_mask0;
            rsp_mask1    <= cmd_mask1;
        end
    end

    // The bank only holds regSrc valid in the response cycle, so data passes straight through.
    assign rd_data0 = (rd_rsp_valid && !rsp_mask0) ? bank_src0 : 32'd0;
    assign rd_data1 = (rd_rsp_valid && !rsp_mask1) ? bank_src1 : 32'd0;

endmodule

// File: tb/tb_regbank_access_arbiter.sv
// Bench for regbank_access_arbiter: bank stand-in, cycle-level reference model and directed scenarios.
module tb_regbank_access_arbiter;
    localparam int MAXB = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rd_valid = 1'b0;
    logic [4:0]  rd_sel0 = '0;
    logic [4:0]  rd_sel1 = '0;
    logic        wr_valid = 1'b0;
    logic [4:0]  wr_sel = '0;
    logic [31:0] wr_data = '0;
    logic        rd_ready, wr_ready, rd_rsp_valid;
    logic [31:0] rd_data0, rd_data1;
    logic        bank_csbar, bank_rdwrbar, bank_rst_n;
    logic [4:0]  bank_sel_src0, bank_sel_src1, bank_sel_dst;
    logic [31:0] bank_wdata, bank_src0, bank_src1;

    always #5 clk = ~clk;

    regbank_access_arbiter #(.MAX_WR_BURST(MAXB), .ZERO_REG(1'b1)) dut (
        .clk(clk), .reset(rst),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_sel0(rd_sel0), .rd_sel1(rd_sel1),
        .rd_rsp_valid(rd_rsp_valid), .rd_data0(rd_data0), .rd_data1(rd_data1),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_sel(wr_sel), .wr_data(wr_data),
        .bank_csbar(bank_csbar), .bank_rdwrbar(bank_rdwrbar),
        .bank_sel_src0(bank_sel_src0), .bank_sel_src1(bank_sel_src1),
        .bank_sel_dst(bank_sel_dst), .bank_wdata(bank_wdata), .bank_rst_n(bank_rst_n),
        .bank_src0(bank_src0), .bank_src1(bank_src1)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] init_pat(input int i);
        return 32'hA5A5_0000 | 32'(i);
    endfunction

    // Bank stand-in: reset loads a nonzero pattern so that masking of reg 0 is observable.
    logic [31:0] bmem [32];
    logic [31:0] bq0, bq1;
    logic        bvld = 1'b0;
    always @(posedge clk) begin
        bvld <= 1'b0;
        if (!bank_rst_n) begin
            for (int i = 0; i < 32; i++) bmem[i] <= init_pat(i);
        end else if (!bank_csbar) begin
            if (!bank_rdwrbar) begin
                bmem[bank_sel_dst] <= bank_wdata;
            end else begin
                bq0  <= bmem[bank_sel_src0];
                bq1  <= bmem[bank_sel_src1];
                bvld <= 1'b1;
            end
        end
    end
    assign bank_src0 = bvld ? bq0 : 32'hBAD0_BAD0;
    assign bank_src1 = bvld ? bq1 : 32'hBAD1_BAD1;

    // Reference model: architectural register contents plus per-cycle expected bank command and response.
    typedef struct packed { logic v; logic wr; logic [4:0] s0; logic [4:0] s1; logic [4:0] dst; logic [31:0] wd; } cmd_t;
    typedef struct packed { logic v; logic [31:0] d0; logic [31:0] d1; } rsp_t;
    cmd_t        cmd_q [4];
    rsp_t        rsp_q [4];
    logic [31:0] ref_mem [32];
    int          phase = 0;
    int          streak = 0;

    always @(negedge clk) begin : model
        int   c, n1, n2;
        logic ew, er;
        c  = cyc % 4;
        n1 = (cyc + 1) % 4;
        n2 = (cyc + 2) % 4;
        if (rst) begin
            chk("rst_rd_ready", rd_ready, 0);
            chk("rst_wr_ready", wr_ready, 0);
            chk("rst_rsp_valid", rd_rsp_valid, 0);
            chk("rst_rd_data0", rd_data0, 0);
            chk("rst_rd_data1", rd_data1, 0);
            chk("rst_csbar", bank_csbar, 1);
            chk("rst_rdwrbar", bank_rdwrbar, 1);
            chk("rst_sels", {bank_sel_src0, bank_sel_src1, bank_sel_dst}, 0);
            chk("rst_wdata", bank_wdata, 0);
            chk("rst_bank_rst_n", bank_rst_n, 0);
            phase  = 0;
            streak = 0;
            for (int i = 0; i < 4; i++) begin
                cmd_q[i] = '0;
                rsp_q[i] = '0;
            end
            for (int i = 0; i < 32; i++) ref_mem[i] = init_pat(i);
        end else begin
            ew = (phase == 2) && wr_valid && !(rd_valid && streak == MAXB);
            er = (phase == 2) && rd_valid && !ew;
            chk("wr_ready", wr_ready, ew);
            chk("rd_ready", rd_ready, er);
            chk("bank_rst_n", bank_rst_n, phase == 2);
            chk("bank_csbar", bank_csbar, !cmd_q[c].v);
            if (cmd_q[c].v && cmd_q[c].wr) begin
                chk("cmd_rdwrbar", bank_rdwrbar, 0);
                chk("cmd_dst", bank_sel_dst, cmd_q[c].dst);
                chk("cmd_wdata", bank_wdata, cmd_q[c].wd);
            end else if (cmd_q[c].v) begin
                chk("cmd_rdwrbar", bank_rdwrbar, 1);
                chk("cmd_src", {bank_sel_src0, bank_sel_src1}, {cmd_q[c].s0, cmd_q[c].s1});
            end
            chk("rsp_valid", rd_rsp_valid, rsp_q[c].v);
            chk("rsp_data0", rd_data0, rsp_q[c].d0);
            chk("rsp_data1", rd_data1, rsp_q[c].d1);
            cmd_q[c] = '0;
            rsp_q[c] = '0;
            if (ew && wr_sel != 5'd0) begin
                cmd_q[n1].v   = 1'b1;
                cmd_q[n1].wr  = 1'b1;
                cmd_q[n1].dst = wr_sel;
                cmd_q[n1].wd  = wr_data;
                ref_mem[wr_sel] = wr_data;
            end
            if (er) begin
                cmd_q[n1].v  = 1'b1;
                cmd_q[n1].wr = 1'b0;
                cmd_q[n1].s0 = rd_sel0;
                cmd_q[n1].s1 = rd_sel1;
                rsp_q[n2].v  = 1'b1;
                rsp_q[n2].d0 = (rd_sel0 == 5'd0) ? 32'd0 : ref_mem[rd_sel0];
                rsp_q[n2].d1 = (rd_sel1 == 5'd0) ? 32'd0 : ref_mem[rd_sel1];
            end
            if (ew && rd_valid) streak = (streak < MAXB) ? streak + 1 : MAXB;
            else if (er || !rd_valid) streak = 0;
            if (phase < 2) phase++;
        end
    end

    task automatic release_and_check();
        rd_valid = 1'b1; rd_sel0 = 5'd0; rd_sel1 = 5'd0;
        rst = 1'b0;
        @(negedge clk);
        chk("init_rd_ready", rd_ready, 0);
        chk("init_bank_rst_n", bank_rst_n, 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("clr_rd_ready", rd_ready, 0);
        chk("clr_bank_rst_n", bank_rst_n, 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("run_rd_ready", rd_ready, 1);
        chk("run_bank_rst_n", bank_rst_n, 1);
        @(posedge clk); #1;
        rd_valid = 1'b0;
    endtask

    task automatic do_write(input logic [4:0] sel, input logic [31:0] data);
        int n;
        n = 0;
        wr_valid = 1'b1; wr_sel = sel; wr_data = data;
        @(negedge clk);
        while (!wr_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("wr_accept", wr_ready, 1);
        @(posedge clk); #1;
        wr_valid = 1'b0;
    endtask

    task automatic do_read(input logic [4:0] s0, input logic [4:0] s1);
        int n;
        n = 0;
        rd_valid = 1'b1; rd_sel0 = s0; rd_sel1 = s1;
        @(negedge clk);
        while (!rd_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("rd_accept", rd_ready, 1);
        @(posedge clk); #1;
        rd_valid = 1'b0;
    endtask

    initial begin : stim
        logic [11:0] order;
        logic [6:0]  seen;
        logic [31:0] d [7];
        repeat (3) @(posedge clk);
        #1;
        release_and_check();

        // Write then immediately read the same register.
        do_write(5'd5, 32'hDEAD_BEEF);
        do_read(5'd5, 5'd0);
        @(negedge clk);
        chk("rd_cmd_csbar", bank_csbar, 0);
        chk("rd_cmd_sel0", bank_sel_src0, 5);
        @(negedge clk);
        chk("wr_rd_rsp_valid", rd_rsp_valid, 1);
        chk("wr_rd_data0", rd_data0, 32'hDEAD_BEEF);
        chk("wr_rd_data1", rd_data1, 0);
        @(posedge clk); #1;

        // Both requesters held for 12 cycles.
        rd_valid = 1'b1; rd_sel0 = 5'd1; rd_sel1 = 5'd2;
        wr_valid = 1'b1; wr_sel = 5'd7; wr_data = 32'h77;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            order[11-i] = wr_ready;
            @(posedge clk); #1;
        end
        rd_valid = 1'b0; wr_valid = 1'b0;
        chk("grant_order", 32'(order), 32'(12'b1111_0111_1011));
        repeat (2) @(posedge clk);
        #1;

        // Writes to reg 0 complete the handshake but never reach the bank.
        do_write(5'd0, 32'h1234);
        @(negedge clk);
        chk("r0_write_dropped", bank_csbar, 1);
        @(posedge clk); #1;
        do_read(5'd0, 5'd0);
        @(negedge clk);
        @(negedge clk);
        chk("r0_rsp_valid", rd_rsp_valid, 1);
        chk("r0_data0", rd_data0, 0);
        chk("r0_data1", rd_data1, 0);
        @(posedge clk); #1;

        // Back-to-back reads r1..r4.
        do_write(5'd1, 32'h11);
        do_write(5'd2, 32'h22);
        do_write(5'd3, 32'h33);
        do_write(5'd4, 32'h44);
        for (int k = 0; k < 7; k++) begin
            rd_valid = (k < 4);
            rd_sel0  = 5'(k + 1);
            rd_sel1  = 5'(k + 1);
            @(negedge clk);
            seen[k] = rd_rsp_valid;
            d[k]    = rd_data0;
            @(posedge clk); #1;
        end
        rd_valid = 1'b0;
        chk("b2b_rsp_pattern", 32'(seen), 32'(7'b0111100));
        for (int k = 0; k < 4; k++) chk("b2b_data", d[k+2], 32'h11 * (k + 1));

        // Reset lands between a read's command cycle and its response cycle.
        do_read(5'd3, 5'd4);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_csbar", bank_csbar, 1);
        chk("midrst_rsp_valid", rd_rsp_valid, 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("midrst_rsp_valid_e2", rd_rsp_valid, 0);
        @(posedge clk); #1;
        release_and_check();
        do_read(5'd5, 5'd1);
        repeat (3) @(posedge clk);
        #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not reach its end, checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

endmodule
